vx_banked_operand_collector: RTL
================================

# vx_banked_operand_collector

Per-issue-slot operand collector that gathers up to `NUM_SRCS` source registers for one instruction at a time from a multi-bank GPR file owned by the block. Reads to distinct banks run in parallel; operands sharing a bank are serialised, and duplicate register IDs share one read. It sits between the scoreboard and the dispatch stage and receives the slot's writeback stream. It is the banked, N-source generalisation of the single-port, three-state operand fetcher.

## Interface
- `NUM_THREADS`, default 4: lanes per warp.
- `XLEN`, default 32: lane data width.
- `NUM_REGS`, default 32: architectural registers per warp; power of 2.
- `NUM_WARPS`, default 4: warps mapped to this slot; power of 2.
- `NUM_SRCS`, default 3: source operands per instruction; range 1..4.
- `NUM_BANKS`, default 2: GPR banks; power of 2, at most `NUM_REGS`.
- `META_W`, default 64: opaque instruction fields passed through unchanged.
- Derived widths: `NR_W = log2(NUM_REGS)` and `WIS_W = max(1, log2(NUM_WARPS))`.
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid` / `in_ready`  in / out  1  instruction handshake from the scoreboard.
- `in_wis`  in  `WIS_W`  warp index within the slot.
- `in_tmask`  in  `NUM_THREADS`  thread mask.
- `in_rs`  in  `NUM_SRCS*NR_W`  source register IDs; operand k is slice k.
- `in_meta`  in  `META_W`  pass-through fields.
- `wb_valid`  in  1  writeback strobe.
- `wb_wis`  in  `WIS_W`  writeback warp index.
- `wb_rd`  in  `NR_W`  destination register.
- `wb_tmask`  in  `NUM_THREADS`  lane write enables.
- `wb_data`  in  `NUM_THREADS*XLEN`  lane data.
- `out_valid` / `out_ready`  out / in  1  handshake to dispatch.
- `out_wis`, `out_tmask`, `out_meta`  out  as for the inputs  registered copies of the input fields.
- `out_data`  out  `NUM_SRCS*NUM_THREADS*XLEN`  operand k is slice k.

## Operation
- **GPR storage**
  - One dual-port RAM per bank, with 1 write port and 1 synchronous read port.
  - Register r of warp w lives in bank `r % NUM_BANKS` at address `{w, r / NUM_BANKS}`.
  - Writeback writes the lanes selected by `wb_tmask`. A writeback with `wb_rd == 0` is dropped.
- **FSM state IDLE**
  - `in_ready = 1`.
  - On `in_valid`: latch the instruction and set each operand's pending bit = (`rs_k != 0`). Zero-register operands are set to 0.
  - Go to COLLECT, or straight to DONE if nothing is pending.
- **FSM state COLLECT**
  - Each cycle, for each bank, select the lowest-index pending operand mapped to that bank and issue its read.
  - Every other pending operand with the same register ID rides on that read.
  - Read data is captured one cycle after issue, and the captured operands clear their pending bits.
  - Go to DONE in the cycle after the last capture.
- **FSM state DONE**
  - `out_valid = 1`.
  - On `out_ready`: if `in_valid` is also high, accept the next instruction in the same cycle (`in_ready = out_ready` in DONE); otherwise go to IDLE.
- **Handshake rule:** while `out_valid && !out_ready`, every output is held stable.
- **Reset values:** `out_valid = 0`, `in_ready = 1` (state IDLE), `out_data`/`out_meta`/`out_wis`/`out_tmask` = 0, all pending bits clear. GPR contents are not reset.
- **Reset mid-operation:** the in-flight instruction is discarded and `out_valid` drops immediately (asynchronous reset).

## Timing
- Latency from the `in_valid && in_ready` edge to `out_valid`:
  - no nonzero sources: 1 cycle;
  - all nonzero sources in distinct banks, or duplicates of one register: 3 cycles (read issue, capture, DONE);
  - each extra serialised bank conflict: +1 cycle.
- Worked example, `NUM_BANKS=2`, rs = {1,3,5}: all three map to bank 1, giving 3 reads and 5 cycles.
- Maximum throughput: 1 instruction per 3 cycles for conflict-free operands, 1 per cycle when all sources are x0.
- A writeback and a read to the same bank in the same cycle are both performed. The RAM returns the old value (no read-during-write check).

## Configuration
- `OPC_WB_BYPASS_EN` defined:
  - While in COLLECT, a writeback with `wb_wis == held wis` and `wb_rd` equal to a nonzero source of the held instruction merges the `wb_tmask` lanes into that operand.
  - This applies whether the operand is pending, in flight (the merge is applied to the captured value), or already captured.
  - The operand stays pending if its read has not issued yet.
  - No bypass is applied in DONE.
- `OPC_WB_BYPASS_EN` undefined: no forwarding. A same-cycle collision yields the pre-write RAM value, and the scoreboard is responsible for hazard freedom.

## Test plan
- **Zero registers:** after reset, issue rs={0,0,0}, meta=0xAB → `out_valid` 1 cycle later, data all 0, `out_meta`=0xAB, `in_ready` was 1 during reset release.
- **Conflict-free read:** write r2=0x11, r3=0x22 (all lanes, warp 1), then issue rs={2,3,0} → `out_valid` 3 cycles after accept, operands {0x11, 0x22, 0}.
- **Bank conflict and dedupe:** with `NUM_BANKS=2`, rs={1,3,5} → `out_valid` 5 cycles after accept. Then rs={7,7,7} → 3 cycles, all operands equal to r7.
- **Bypass:** issue rs={4,0,0} and, on the read-issue cycle, write r4=0x55 with lanes 0-1 → with the macro defined, lanes 0-1 are 0x55 and lanes 2-3 are old. Without the macro, all lanes are old.
- **Backpressure and back-to-back:** hold `out_ready`=0 for 4 cycles → outputs stable and `in_ready`=0. Raise `out_ready` with `in_valid`=1 → the second instruction is accepted the same cycle.
- **Reset mid-collect:** assert `reset_n`=0 in COLLECT → `out_valid`=0 and `in_ready`=1 asynchronously; the next instruction completes normally.

Source files
------------

// File: rtl/vx_banked_operand_collector.sv
// vx_banked_operand_collector
//   Per-issue-slot operand collector. Accepts one instruction at a time and
//   gathers up to NUM_SRCS source operands from a banked GPR file that the
//   block owns. Reads to different banks proceed in parallel. Operands that
//   share a bank are serialised, and duplicate register IDs share one read.
//   The slot's writeback stream updates the GPR file.
//
//   Optional feature macro: OPC_WB_BYPASS_EN
//     When defined, writebacks that land while an instruction is collecting
//     are merged into matching operands. The operand can be pending, in flight
//     or already captured.
//
//   Ports
//     clk, reset_n                  clock, asynchronous active-low reset
//     in_valid/in_ready             instruction handshake from the scoreboard
//     in_wis, in_tmask, in_rs       warp index, thread mask, source IDs (slice k)
//     in_meta                       opaque fields passed through unchanged
//     wb_valid, wb_wis, wb_rd       writeback strobe, warp, destination register
//     wb_tmask, wb_data             writeback lane enables and lane data
//     out_valid/out_ready           handshake to dispatch
//     out_wis, out_tmask, out_meta  registered copies of the instruction fields
//     out_data                      collected operands, operand k is slice k
module vx_banked_operand_collector #(
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32,
  parameter int NUM_REGS    = 32,
  parameter int NUM_WARPS   = 4,
  parameter int NUM_SRCS    = 3,
  parameter int NUM_BANKS   = 2,
  parameter int META_W      = 64,
  parameter int NR_W        = $clog2(NUM_REGS),
  parameter int WIS_W       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WIS_W-1:0]                   in_wis,
  input  logic [NUM_THREADS-1:0]             in_tmask,
  input  logic [NUM_SRCS*NR_W-1:0]           in_rs,
  input  logic [META_W-1:0]                  in_meta,
  input  logic                               wb_valid,
  input  logic [WIS_W-1:0]                   wb_wis,
  input  logic [NR_W-1:0]                    wb_rd,
  input  logic [NUM_THREADS-1:0]             wb_tmask,
  input  logic [NUM_THREADS*XLEN-1:0]        wb_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [WIS_W-1:0]                   out_wis,
  output logic [NUM_THREADS-1:0]             out_tmask,
  output logic [META_W-1:0]                  out_meta,
  output logic [NUM_SRCS*NUM_THREADS*XLEN-1:0] out_data
);

  localparam int LW     = NUM_THREADS * XLEN;
  localparam int LB     = $clog2(NUM_BANKS);
  localparam int BK_W   = (LB > 0) ? LB : 1;
  localparam int ROW_W  = (NR_W - LB > 0) ? (NR_W - LB) : 1;
  localparam int ADDR_W = WIS_W + ROW_W;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int SI_W   = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  // Register r lives in bank r % NUM_BANKS, row r / NUM_BANKS.
  function automatic logic [BK_W-1:0] bank_of(input logic [NR_W-1:0] r);
    bank_of = BK_W'(int'(r) % NUM_BANKS);
  endfunction

  function automatic logic [ROW_W-1:0] row_of(input logic [NR_W-1:0] r);
    row_of = ROW_W'(int'(r) / NUM_BANKS);
  endfunction

`ifdef OPC_WB_BYPASS_EN
  // Replace the lanes selected by m with the lanes of new_v.
  function automatic logic [LW-1:0] lane_merge(input logic [LW-1:0] old_v,
                                               input logic [NUM_THREADS-1:0] m,
                                               input logic [LW-1:0] new_v);
    lane_merge = old_v;
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (m[t]) begin
        lane_merge[t*XLEN +: XLEN] = new_v[t*XLEN +: XLEN];
      end else begin
        lane_merge[t*XLEN +: XLEN] = old_v[t*XLEN +: XLEN];
      end
    end
  endfunction
`endif

  state_t                              state_r;
  logic [WIS_W-1:0]                    wis_r;
  logic [NUM_THREADS-1:0]              tmask_r;
  logic [META_W-1:0]                   meta_r;
  logic [NUM_SRCS-1:0][NR_W-1:0]       rs_r;
  logic [NUM_SRCS-1:0]                 pend_r;   // operand still waits for data
  logic [NUM_SRCS-1:0]                 iss_r;    // read issued last cycle, data on RAM output now
  logic [NUM_SRCS-1:0][LW-1:0]         data_r;

  logic                                acc_s;
  logic [NUM_SRCS-1:0]                 nz_s;
  logic [NUM_SRCS-1:0]                 iss_s;
  logic [NUM_SRCS-1:0][LW-1:0]         cap_s;
  logic [NUM_BANKS-1:0]                sel_valid_s;
  logic [SI_W-1:0]                     sel_idx_s   [NUM_BANKS];
  logic [ADDR_W-1:0]                   rd_addr_s   [NUM_BANKS];
  logic [LW-1:0]                       bank_rdata_s[NUM_BANKS];
  logic                                wr_en_s;
  logic [BK_W-1:0]                     wr_bank_s;
  logic [ADDR_W-1:0]                   wr_addr_s;

`ifdef OPC_WB_BYPASS_EN
  logic [NUM_SRCS-1:0]                   hit_s;
  logic [NUM_SRCS-1:0][NUM_THREADS-1:0]  byp_mask_r; // writeback lanes seen on the read-issue cycle
  logic [LW-1:0]                         byp_data_r;
`endif

  assign acc_s     = in_valid & in_ready;
  assign in_ready  = (state_r == S_IDLE) | ((state_r == S_DONE) & out_ready);
  assign out_valid = (state_r == S_DONE);
  assign out_wis   = wis_r;
  assign out_tmask = tmask_r;
  assign out_meta  = meta_r;
  assign out_data  = data_r;

  assign wr_en_s   = wb_valid & (wb_rd != '0);
  assign wr_bank_s = bank_of(wb_rd);
  assign wr_addr_s = {wb_wis, row_of(wb_rd)};

  // Nonzero source flags of the incoming instruction.
  always_comb begin
    for (int k = 0; k < NUM_SRCS; k++) begin
      nz_s[k] = (in_rs[k*NR_W +: NR_W] != '0);
    end
  end

  // Per bank, pick the lowest-index pending operand whose read has not issued.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      sel_valid_s[b] = 1'b0;
      sel_idx_s[b]   = '0;
      for (int k = NUM_SRCS - 1; k >= 0; k--) begin
        if ((state_r == S_COLLECT) && pend_r[k] && !iss_r[k] &&
            (bank_of(rs_r[k]) == BK_W'(b))) begin
          sel_valid_s[b] = 1'b1;
          sel_idx_s[b]   = SI_W'(k);
        end else begin
          sel_valid_s[b] = sel_valid_s[b];
        end
      end
      rd_addr_s[b] = {wis_r, row_of(rs_r[sel_idx_s[b]])};
    end
  end

  // Operands issued this cycle: the selected one plus all same-ID riders.
  always_comb begin
    for (int k = 0; k < NUM_SRCS; k++) begin
      if ((state_r == S_COLLECT) && pend_r[k] && !iss_r[k] &&
          sel_valid_s[bank_of(rs_r[k])] &&
          (rs_r[sel_idx_s[bank_of(rs_r[k])]] == rs_r[k])) begin
        iss_s[k] = 1'b1;
      end else begin
        iss_s[k] = 1'b0;
      end
    end
  end

`ifdef OPC_WB_BYPASS_EN
  // Writeback targets a nonzero source of the held instruction while collecting.
  always_comb begin
    for (int k = 0; k < NUM_SRCS; k++) begin
      if ((state_r == S_COLLECT) && wb_valid && (wb_wis == wis_r) &&
          (rs_r[k] != '0) && (wb_rd == rs_r[k])) begin
        hit_s[k] = 1'b1;
      end else begin
        hit_s[k] = 1'b0;
      end
    end
  end
`endif

  // Next operand values: capture read data and apply any bypass merges.
  always_comb begin
    for (int k = 0; k < NUM_SRCS; k++) begin
      if (iss_r[k]) begin
`ifdef OPC_WB_BYPASS_EN
        cap_s[k] = lane_merge(bank_rdata_s[bank_of(rs_r[k])], byp_mask_r[k], byp_data_r);
`else
        cap_s[k] = bank_rdata_s[bank_of(rs_r[k])];
`endif
      end else begin
        cap_s[k] = data_r[k];
      end
`ifdef OPC_WB_BYPASS_EN
      // Pending-but-unissued operands are left alone: their later read sees the RAM update.
      if (hit_s[k] && (iss_r[k] || !pend_r[k])) begin
        cap_s[k] = lane_merge(cap_s[k], wb_tmask, wb_data);
      end else begin
        cap_s[k] = cap_s[k];
      end
`endif
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [LW-1:0] mem [DEPTH];
    logic [LW-1:0] rdata_r;

    // Write port: lane-masked writeback.
    always_ff @(posedge clk) begin
      if (wr_en_s && (wr_bank_s == BK_W'(b))) begin
        for (int t = 0; t < NUM_THREADS; t++) begin
          if (wb_tmask[t]) begin
            mem[wr_addr_s][t*XLEN +: XLEN] <= wb_data[t*XLEN +: XLEN];
          end
        end
      end
    end

    // Synchronous read port; a same-cycle write is not seen (old data returned).
    always_ff @(posedge clk) begin
      if (sel_valid_s[b]) begin
        rdata_r <= mem[rd_addr_s[b]];
      end
    end

    assign bank_rdata_s[b] = rdata_r;
  end

  // Control FSM and the instruction/operand holding registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
      wis_r   <= '0;
      tmask_r <= '0;
      meta_r  <= '0;
      rs_r    <= '0;
      pend_r  <= '0;
      iss_r   <= '0;
      data_r  <= '0;
`ifdef OPC_WB_BYPASS_EN
      byp_mask_r <= '0;
      byp_data_r <= '0;
`endif
    end else if (acc_s) begin
      wis_r   <= in_wis;
      tmask_r <= in_tmask;
      meta_r  <= in_meta;
      rs_r    <= in_rs;
      pend_r  <= nz_s;
      iss_r   <= '0;
      data_r  <= '0;
`ifdef OPC_WB_BYPASS_EN
      byp_mask_r <= '0;
`endif
      state_r <= (nz_s != '0) ? S_COLLECT : S_DONE;
    end else begin
      case (state_r)
        S_COLLECT: begin
          data_r <= cap_s;
          pend_r <= pend_r & ~iss_r;
          iss_r  <= iss_s;
`ifdef OPC_WB_BYPASS_EN
          for (int k = 0; k < NUM_SRCS; k++) begin
            byp_mask_r[k] <= (iss_s[k] && hit_s[k]) ? wb_tmask : '0;
          end
          byp_data_r <= wb_data;
`endif
          // Done once everything still pending is being captured this cycle.
          if ((pend_r & ~iss_r) == '0) begin
            state_r <= S_DONE;
          end else begin
            state_r <= S_COLLECT;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_r <= S_IDLE;
          end else begin
            state_r <= S_DONE;
          end
        end
        S_IDLE:  state_r <= S_IDLE;
        default: state_r <= S_IDLE;
      endcase
    end
  end

endmodule
